// File: rtl/mux_n_to_1_pipe.sv
// mux_n_to_1_pipe
//   Registered N:1 multiplexer with valid/ready flow control. It selects one
//   of N packed WIDTH-bit operands and presents it from a single output
//   register. A one-entry skid register sits behind that output register, so
//   in_ready comes straight from a flop and never depends combinationally on
//   out_ready. In-flight capacity is two beats, and beats leave in the order
//   they arrived.
//
//   Optional feature: define MUX_SEL_ERR_EN to add the sel_err output. It is
//   a flag that travels with each beat and marks beats captured with
//   in_sel >= N. Those beats carry zero data whether or not the macro is
//   defined.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    N*WIDTH packed operands, operand k = in_data[k*WIDTH +: WIDTH]
//   in_sel     operand index, sampled with the beat
//   in_valid   upstream beat valid
//   in_ready   block can accept a beat (registered)
//   out_data   selected operand (zero for out-of-range selects)
//   out_sel    in_sel captured with this beat
//   out_valid  out_data/out_sel valid
//   out_ready  downstream accepts the beat
//   sel_err    (MUX_SEL_ERR_EN only) beat was captured with in_sel >= N
module mux_n_to_1_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]      in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef MUX_SEL_ERR_EN
  ,
  output logic                 sel_err
`endif
);

  if ((2 ** SELW) < N || N < 2 || N > 16) begin : g_param_check
    $error("mux_n_to_1_pipe: need 2 <= N <= 16 and 2**SELW >= N");
  end

  // Only the addressed slice is read, so X on unselected operands cannot
  // reach the result. An out-of-range select yields zero.
  function automatic logic [WIDTH-1:0] select_word(
    input logic [N*WIDTH-1:0] data,
    input logic [SELW-1:0]    sel
  );
    logic [WIDTH-1:0] word;
    word = '0;
    for (int k = 0; k < N; k++) begin
      if (32'(sel) == k) word = data[k*WIDTH +: WIDTH];
    end
    return word;
  endfunction

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q,  main_data_d;
  logic [SELW-1:0]  main_sel_q,   main_sel_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic [SELW-1:0]  skid_sel_q,   skid_sel_d;
  logic             in_ready_q,   in_ready_d;

  logic             in_xfer, out_xfer;
  logic             main_load_in, main_load_skid, skid_load;
  logic [WIDTH-1:0] in_word;

  assign in_word = select_word(in_data, in_sel);

  always_comb begin
    in_xfer  = in_valid & in_ready_q;
    out_xfer = main_valid_q & out_ready;
    // The skid register is only ever filled while in_ready is low, so an
    // input transfer implies that the skid register is empty.
    main_load_skid = skid_valid_q & out_xfer;
    main_load_in   = in_xfer & (~main_valid_q | out_xfer);
    skid_load      = in_xfer & main_valid_q & ~out_xfer;

    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_sel_d   = main_sel_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_sel_d   = skid_sel_q;

    if (main_load_skid) begin
      main_valid_d = 1'b1;
      main_data_d  = skid_data_q;
      main_sel_d   = skid_sel_q;
    end else if (main_load_in) begin
      main_valid_d = 1'b1;
      main_data_d  = in_word;
      main_sel_d   = in_sel;
    end else if (out_xfer) begin
      main_valid_d = 1'b0;
    end

    if (skid_load) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_word;
      skid_sel_d   = in_sel;
    end else if (main_load_skid) begin
      skid_valid_d = 1'b0;
    end

    in_ready_d = ~skid_valid_d;
  end

  // Output/skid stage register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_sel_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_sel_q   <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_sel_q   <= main_sel_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sel_q   <= skid_sel_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;
  assign in_ready  = in_ready_q;

`ifdef MUX_SEL_ERR_EN
  function automatic logic sel_out_of_range(input logic [SELW-1:0] sel);
    return 32'(sel) >= 32'(N);
  endfunction

  logic main_err_q, main_err_d;
  logic skid_err_q, skid_err_d;

  // The error flag follows the same moves as the data it describes. It is
  // cleared when the main register empties, so it is high only alongside
  // out_valid.
  always_comb begin
    main_err_d = main_err_q;
    skid_err_d = skid_err_q;
    if (main_load_skid)    main_err_d = skid_err_q;
    else if (main_load_in) main_err_d = sel_out_of_range(in_sel);
    else if (out_xfer)     main_err_d = 1'b0;
    if (skid_load)           skid_err_d = sel_out_of_range(in_sel);
    else if (main_load_skid) skid_err_d = 1'b0;
  end

  // Error flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_err_q <= 1'b0;
      skid_err_q <= 1'b0;
    end else begin
      main_err_q <= main_err_d;
      skid_err_q <= skid_err_d;
    end
  end

  assign sel_err = main_err_q;
`endif

endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
module tb_mux_n_to_1_pipe;
  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SELW  = 2;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [SELW-1:0]  sel;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N*WIDTH-1:0]   in_data;
  logic [SELW-1:0]      in_sel;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_valid;
  logic                 out_ready;
`ifdef MUX_SEL_ERR_EN
  logic                 sel_err;
`endif

  logic [WIDTH-1:0] words [N];
  beat_t            model_q[$];
  int               vectors = 0;
  int               miscompares = 0;

  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int k = 0; k < N; k++) in_data[k*WIDTH +: WIDTH] = words[k];
  end

  mux_n_to_1_pipe #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_SEL_ERR_EN
    , .sel_err(sel_err)
`endif
  );

  // Reference model: a FIFO of at most two beats. A push happens when
  // in_valid is high and fewer than two beats are held. A pop happens when
  // out_ready is high and a beat is held. Then one clock edge is advanced.
  task automatic tick();
    bit    ix, ox;
    beat_t b;
    ix = in_valid && (model_q.size() < 2);
    ox = out_ready && (model_q.size() > 0);
    b.sel  = in_sel;
    b.data = (int'(in_sel) < N) ? words[in_sel] : '0;
    if (ox) void'(model_q.pop_front());
    if (ix) model_q.push_back(b);
    @(posedge clk);
    #1;
  endtask

  task automatic set_sweep_words();
    words[0] = 32'hAAAA0000;
    words[1] = 32'hBBBB0001;
    words[2] = 32'hCCCC0002;
    words[3] = 32'hDDDD0003;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; out_ready = 1'b0;
    for (int k = 0; k < N; k++) words[k] = '0;
    #2;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++;
    if (out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data got %h want 0", out_data); end
    vectors++;
    if (out_sel !== 2'd0) begin miscompares++; $display("FAIL reset_out_sel got %0d want 0", out_sel); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_select_sweep();
    set_sweep_words();
    out_ready = 1'b1;
    for (int s = 0; s < N; s++) begin
      in_valid = 1'b1; in_sel = SELW'(s);
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== words[s] || out_sel !== SELW'(s)) begin
        miscompares++;
        $display("FAIL sweep_sel%0d got v=%b d=%h s=%0d want v=1 d=%h s=%0d",
                 s, out_valid, out_data, out_sel, words[s], s);
      end
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL sweep_drain got v=%b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    set_sweep_words();
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'd1; tick();
    in_sel = 2'd2; tick();
    in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hBBBB0001) begin
        miscompares++;
        $display("FAIL bp_stall%0d got rdy=%b v=%b d=%h want rdy=0 v=1 d=bbbb0001",
                 c, in_ready, out_valid, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'hCCCC0002 || out_sel !== 2'd2) begin
      miscompares++;
      $display("FAIL bp_release got rdy=%b v=%b d=%h s=%0d want rdy=1 v=1 d=cccc0002 s=2",
               in_ready, out_valid, out_data, out_sel);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty got v=%b want 0", out_valid); end
  endtask

  task automatic test_push_pop();
    set_sweep_words();
    out_ready = 1'b1;
    in_valid = 1'b1; in_sel = 2'd0; tick();
    in_sel = 2'd3; tick();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'hDDDD0003 || out_sel !== 2'd3) begin
      miscompares++;
      $display("FAIL pushpop got rdy=%b v=%b d=%h s=%0d want rdy=1 v=1 d=dddd0003 s=3",
               in_ready, out_valid, out_data, out_sel);
    end
    in_valid = 1'b0; tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL pushpop_empty got v=%b want 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    set_sweep_words();
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'd2; tick();
    in_sel = 2'd3; tick();
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_full got rdy=%b v=%b want rdy=0 v=1", in_ready, out_valid);
    end
    #2 rst = 1'b1;
    #1;
    model_q.delete();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_async got v=%b rdy=%b d=%h want v=0 rdy=1 d=0", out_valid, in_ready, out_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL midrst_stale%0d got v=%b rdy=%b want v=0 rdy=1", c, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random_soak();
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < N; k++) words[k] = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_sel    = SELW'($urandom_range(0, N - 1));
      vectors++;
      if (out_valid !== (model_q.size() > 0) || in_ready !== (model_q.size() < 2)) begin
        miscompares++;
        $display("FAIL soak_ctrl cyc%0d got v=%b rdy=%b want v=%b rdy=%b",
                 c, out_valid, in_ready, model_q.size() > 0, model_q.size() < 2);
      end
      if (model_q.size() > 0) begin
        vectors++;
        if (out_data !== model_q[0].data || out_sel !== model_q[0].sel) begin
          miscompares++;
          $display("FAIL soak_beat cyc%0d got d=%h s=%0d want d=%h s=%0d",
                   c, out_data, out_sel, model_q[0].data, model_q[0].sel);
        end
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    vectors++;
    if (out_valid !== 1'b0 || model_q.size() != 0) begin
      miscompares++;
      $display("FAIL soak_drain got v=%b want 0 (model %0d left)", out_valid, model_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_select_sweep();
    test_backpressure();
    test_push_pop();
    test_reset_midstream();
    test_random_soak();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
